// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
// Imported by the FIFO and the receive controller.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rx_state_e;

  localparam int DEF_DEPTH         = 8;
  localparam int DEF_TIMEOUT_TICKS = 160;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with occupancy count.
// Storage is unreset; pointers and count are.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int DW    = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;
  logic          do_push;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage write; no reset on the array.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Occupancy tracks push minus pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      unique case (1'b1)
        do_push && !do_pop: count <= count + (AW+1)'(1);
        do_pop && !do_push: count <= count - (AW+1)'(1);
        default:            count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive controller: enable FSM, byte FIFO,
// sticky overrun and idle timeout.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH         = DEF_DEPTH,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  localparam int CW           = $clog2(DEPTH) + 1,
  localparam int TW           = $clog2(TIMEOUT_TICKS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_en,
  input  logic          i_clk_rx,
  input  logic          i_rx_done,
  input  logic [7:0]    i_rx_data,
  output logic          o_div_en,
  output logic          o_valid,
  output logic [7:0]    o_data,
  input  logic          i_ready,
  output logic [CW-1:0] o_count,
  output logic          o_overrun,
  input  logic          i_clr_ovr,
  output logic          o_timeout
);

  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_TICKS);

  rx_state_e     state_q;
  rx_state_e     state_d;
  logic [TW-1:0] idle_q;
  logic [TW-1:0] idle_d;
  logic          timeout_d;
  logic          run;
  logic          push;
  logic          pop;
  logic          drop;
  logic          full;
  logic          empty;
  logic [7:0]    rdata;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (i_rx_data),
    .rdata (rdata),
    .count (o_count),
    .full  (full),
    .empty (empty)
  );

  assign run      = (state_q == ST_RUN);
  assign o_div_en = run;
  assign o_valid  = !empty;
  assign o_data   = o_valid ? rdata : 8'h00;
  assign pop      = o_valid && i_ready;
  assign push     = i_rx_done && run && (!full || pop);
  assign drop     = i_rx_done && run && full && !pop;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; re-enable beats empty in DRAIN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_OFF: begin
        if (i_en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!i_en) state_d = empty ? ST_OFF : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (i_en)       state_d = ST_RUN;
        else if (empty) state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Idle counter next value and timeout edge.
  always_comb begin
    idle_d = idle_q;
    if (push || empty || !run || state_d != ST_RUN) begin
      idle_d = '0;
    end else if (i_clk_rx && idle_q != TMAX) begin
      idle_d = idle_q + TW'(1);
    end
    timeout_d = (idle_d == TMAX) && (idle_q != TMAX);
  end

  // Idle counter and one-shot timeout pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_q    <= '0;
      o_timeout <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      o_timeout <= timeout_d;
    end
  end

  // Sticky overrun; a new drop beats a clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_overrun <= 1'b0;
    end else if (drop) begin
      o_overrun <= 1'b1;
    end else if (i_clr_ovr) begin
      o_overrun <= 1'b0;
    end
  end

endmodule
